// File: rtl/ppu_pixel_fifo.sv
// ppu_pixel_fifo: FWFT pixel FIFO tagging each PPU dot with sof/eol from raster counters.
// Optional `PPU_FIFO_DROP_CNT_EN adds a saturating drop_count output.
module ppu_pixel_fifo #(
    parameter int DEPTH       = 256,
    parameter int LINE_PIXELS = 256,
    parameter int FRAME_LINES = 240
) (
    input  logic                     ppu_clk,
    input  logic                     reset,
    input  logic                     pix_valid,
    input  logic [5:0]               pix_data,
    input  logic                     frame_start,
    output logic [5:0]               out_data,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clear_overflow
`ifdef PPU_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int XW = $clog2(LINE_PIXELS);
    localparam int YW = $clog2(FRAME_LINES);

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [XW-1:0] x_q, x_d, cur_x;
    logic [YW-1:0] y_q, y_d, cur_y;
    logic          full, empty, push, pop, drop, sof, eol;
    logic          overflow_q, overflow_d;
    logic [7:0]    head;

    assign level = wr_ptr_q - rd_ptr_q;

    always_comb begin
        empty      = level == '0;
        full       = level == (AW+1)'(DEPTH);
        pop        = !empty && out_ready;
        push       = pix_valid && (!full || pop);
        drop       = pix_valid && full && !pop;
        cur_x      = frame_start ? '0 : x_q;
        cur_y      = frame_start ? '0 : y_q;
        sof        = cur_x == '0 && cur_y == '0;
        eol        = cur_x == XW'(LINE_PIXELS - 1);
        // counters advance on every strobe, dropped or not, so geometry survives overflow
        x_d        = !pix_valid ? x_q : eol ? '0 : cur_x + XW'(1);
        y_d        = !pix_valid ? y_q : !eol ? cur_y :
                     cur_y == YW'(FRAME_LINES - 1) ? '0 : cur_y + YW'(1);
        wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        overflow_d = drop || (overflow_q && !clear_overflow);
        head       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge ppu_clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge ppu_clk)
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {sof, eol, pix_data};

    assign {out_sof, out_eol, out_data} = head;
    assign out_valid = !empty;
    assign overflow  = overflow_q;

`ifdef PPU_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb
        drop_cnt_d = drop ? (clear_overflow ? 16'd1 : drop_cnt_q + {15'd0, drop_cnt_q != 16'hFFFF}) :
                     clear_overflow ? '0 : drop_cnt_q;

    always_ff @(posedge ppu_clk)
        drop_cnt_q <= reset ? '0 : drop_cnt_d;

    assign drop_count = drop_cnt_q;
`endif
endmodule
